pf_ddr4_dqs_dly_trainer: RTL and testbench

Parametrised multi-lane read-DQS delay-line training controller for the DDR4 PHY block. It drives the per-lane IOD dynamic delay-line controls (load, move, direction) and the eye-monitor clear strobes. It sweeps every tap, reads the eye-monitor early/late flags, and finds the widest passing window. It then parks each lane at the centre of that window. It sits between the PHY training sequencer and the DQS lane IODs, one instance per byte-lane group.

---
 rtl/pf_ddr4_dqs_dly_trainer.sv | 237 +++++++++++++++++++++++
 tb/tb_pf_ddr4_dqs_dly_trainer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pf_ddr4_dqs_dly_trainer.sv
// pf_ddr4_dqs_dly_trainer
// Multi-lane read-DQS delay-line trainer. Sweeps every tap of each lane, finds
// the widest passing eye window and parks the lane at its centre.
// Optional feature: define PF_DDR4_DQS_TRAIN_RETRY_EN to re-sweep a failing
// lane once before flagging it.
module pf_ddr4_dqs_dly_trainer #(
    parameter int unsigned NUM_LANES     = 2,
    parameter int unsigned TAP_BITS      = 7,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MIN_WINDOW    = 8
) (
    input  logic                          FAB_CLK,
    input  logic                          ARST_N,
    input  logic                          START,
    input  logic [NUM_LANES-1:0]          EYE_MONITOR_EARLY,
    input  logic [NUM_LANES-1:0]          EYE_MONITOR_LATE,
    input  logic [NUM_LANES-1:0]          DELAY_LINE_OUT_OF_RANGE,
    output logic [NUM_LANES-1:0]          DELAY_LINE_LOAD,
    output logic [NUM_LANES-1:0]          DELAY_LINE_MOVE,
    output logic [NUM_LANES-1:0]          DELAY_LINE_DIRECTION,
    output logic [NUM_LANES-1:0]          EYE_MONITOR_CLEAR_FLAGS,
    output logic                          BUSY,
    output logic                          DONE,
    output logic [NUM_LANES-1:0]          FAIL_LANES,
    output logic [NUM_LANES*TAP_BITS-1:0] TAP_OUT
);

    localparam int unsigned LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TAP_BITS-1:0] TAP_MAX     = '1;
    localparam logic [LANE_W-1:0]   LAST_LANE   = LANE_W'(NUM_LANES - 1);
    localparam logic [SET_W-1:0]    SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TAP_BITS:0]   MIN_WIN     = (TAP_BITS + 1)'(MIN_WINDOW);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_MOVE,
        S_CALC, S_RELOAD, S_POSITION, S_NEXT, S_DONE
    } state_t;

    state_t                      state_q;
    logic [LANE_W-1:0]           lane_q;
    logic [TAP_BITS-1:0]         tap_q;
    logic [TAP_BITS:0]           run_len_q;
    logic [TAP_BITS-1:0]         run_start_q;
    logic [TAP_BITS:0]           best_len_q;
    logic [TAP_BITS-1:0]         best_start_q;
    logic [SET_W-1:0]            settle_q;
    logic [TAP_BITS-1:0]         target_q;
    logic [TAP_BITS-1:0]         pos_rem_q;
    logic                        pos_phase_q;
    logic [NUM_LANES-1:0]        load_q, move_q, dir_q, clr_q, fail_q;
    logic                        busy_q, done_q;
    logic [NUM_LANES*TAP_BITS-1:0] tap_out_q;
`ifdef PF_DDR4_DQS_TRAIN_RETRY_EN
    logic                        retry_q;
`endif

    logic [NUM_LANES-1:0]        lane_oh_d;
    logic                        pass_d, sweep_end_d, run_closes_d;
    logic [TAP_BITS:0]           run_len_d;
    logic [TAP_BITS-1:0]         run_start_d;
    logic [TAP_BITS-1:0]         target_d;

    // Per-tap evaluation of the current lane's flags and window candidate
    always_comb begin
        lane_oh_d    = NUM_LANES'(1) << lane_q;
        pass_d       = ~|((EYE_MONITOR_EARLY | EYE_MONITOR_LATE | DELAY_LINE_OUT_OF_RANGE) & lane_oh_d);
        sweep_end_d  = (|(DELAY_LINE_OUT_OF_RANGE & lane_oh_d)) || (tap_q == TAP_MAX);
        run_len_d    = pass_d ? run_len_q + 1'b1 : run_len_q;
        run_start_d  = (pass_d && run_len_q == '0) ? tap_q : run_start_q;
        run_closes_d = !pass_d || sweep_end_d;
        target_d     = best_start_q + TAP_BITS'(best_len_q >> 1);
    end

    // Training FSM with registered outputs
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            tap_q        <= '0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            settle_q     <= '0;
            target_q     <= '0;
            pos_rem_q    <= '0;
            pos_phase_q  <= 1'b0;
            load_q       <= '0;
            move_q       <= '0;
            dir_q        <= '0;
            clr_q        <= '0;
            fail_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tap_out_q    <= '0;
`ifdef PF_DDR4_DQS_TRAIN_RETRY_EN
            retry_q      <= 1'b0;
`endif
        end else begin
            load_q <= '0;
            move_q <= '0;
            dir_q  <= '0;
            clr_q  <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q   <= S_LOAD;
                        lane_q    <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        fail_q    <= '0;
                        tap_out_q <= '0;
                        load_q    <= NUM_LANES'(1);
`ifdef PF_DDR4_DQS_TRAIN_RETRY_EN
                        retry_q   <= 1'b0;
`endif
                    end
                end
                S_LOAD: begin
                    tap_q        <= '0;
                    run_len_q    <= '0;
                    run_start_q  <= '0;
                    best_len_q   <= '0;
                    best_start_q <= '0;
                    clr_q        <= lane_oh_d;
                    state_q      <= S_CLEAR;
                end
                S_CLEAR: begin
                    settle_q <= '0;
                    state_q  <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_q == SETTLE_LAST) state_q <= S_SAMPLE;
                    else                         settle_q <= settle_q + 1'b1;
                end
                S_SAMPLE: begin
                    run_len_q   <= pass_d ? run_len_d : '0;
                    run_start_q <= run_start_d;
                    if (run_closes_d && run_len_d > best_len_q) begin
                        best_len_q   <= run_len_d;
                        best_start_q <= run_start_d;
                    end
                    if (sweep_end_d) begin
                        state_q <= S_CALC;
                    end else begin
                        move_q  <= lane_oh_d;
                        dir_q   <= lane_oh_d;
                        state_q <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    tap_q   <= tap_q + 1'b1;
                    clr_q   <= lane_oh_d;
                    state_q <= S_CLEAR;
                end
                S_CALC: begin
                    if (best_len_q >= MIN_WIN) begin
                        target_q <= target_d;
                        load_q   <= lane_oh_d;
                        state_q  <= S_RELOAD;
                    end
`ifdef PF_DDR4_DQS_TRAIN_RETRY_EN
                    else if (!retry_q) begin
                        retry_q <= 1'b1;
                        load_q  <= lane_oh_d;
                        state_q <= S_LOAD;
                    end
`endif
                    else begin
                        fail_q   <= fail_q | lane_oh_d;
                        target_q <= '0;
                        load_q   <= lane_oh_d;
                        state_q  <= S_RELOAD;
                    end
                end
                S_RELOAD: begin
                    // First positioning pulse is launched here so POSITION lasts 2*target cycles
                    pos_rem_q   <= target_q - 1'b1;
                    pos_phase_q <= 1'b0;
                    if (target_q != '0) begin
                        move_q  <= lane_oh_d;
                        dir_q   <= lane_oh_d;
                        state_q <= S_POSITION;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_POSITION: begin
                    if (!pos_phase_q) begin
                        pos_phase_q <= 1'b1;
                    end else if (pos_rem_q == '0) begin
                        state_q <= S_NEXT;
                    end else begin
                        move_q      <= lane_oh_d;
                        dir_q       <= lane_oh_d;
                        pos_rem_q   <= pos_rem_q - 1'b1;
                        pos_phase_q <= 1'b0;
                    end
                end
                S_NEXT: begin
                    for (int unsigned i = 0; i < NUM_LANES; i++) begin
                        if (LANE_W'(i) == lane_q) tap_out_q[i*TAP_BITS +: TAP_BITS] <= target_q;
                    end
                    if (lane_q == LAST_LANE) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        lane_q  <= lane_q + 1'b1;
                        load_q  <= lane_oh_d << 1;
                        state_q <= S_LOAD;
`ifdef PF_DDR4_DQS_TRAIN_RETRY_EN
                        retry_q <= 1'b0;
`endif
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign DELAY_LINE_LOAD         = load_q;
    assign DELAY_LINE_MOVE         = move_q;
    assign DELAY_LINE_DIRECTION    = dir_q;
    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign BUSY                    = busy_q;
    assign DONE                    = done_q;
    assign FAIL_LANES              = fail_q;
    assign TAP_OUT                 = tap_out_q;

endmodule

// File: tb/tb_pf_ddr4_dqs_dly_trainer.sv
// Directed bench for pf_ddr4_dqs_dly_trainer with a behavioural IOD/eye model.
module tb_pf_ddr4_dqs_dly_trainer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [1:0] early, late, oor;
    logic [1:0] load, move, dir, clr, fail;
    logic       busy, done;
    logic [9:0] tap_out;

    pf_ddr4_dqs_dly_trainer #(
        .NUM_LANES(2), .TAP_BITS(5), .SETTLE_CYCLES(2), .MIN_WINDOW(4)
    ) dut (
        .FAB_CLK(clk), .ARST_N(rst_n), .START(start),
        .EYE_MONITOR_EARLY(early), .EYE_MONITOR_LATE(late),
        .DELAY_LINE_OUT_OF_RANGE(oor),
        .DELAY_LINE_LOAD(load), .DELAY_LINE_MOVE(move),
        .DELAY_LINE_DIRECTION(dir), .EYE_MONITOR_CLEAR_FLAGS(clr),
        .BUSY(busy), .DONE(done), .FAIL_LANES(fail), .TAP_OUT(tap_out)
    );

    always #5 clk = ~clk;

    // IOD model: pass map per lane, out-of-range from a given tap upward
    logic [31:0] pmap [2];
    int          oor_at [2];
    int          tap_m [2];
    int          load_cnt [2], clr_cnt [2], move_cnt [2];
    int          b_load [2], b_clr [2], b_move [2];
    int          adj_err = 0, dir_err = 0, cyc = 0;
    logic [1:0]  move_prev = '0;
    int          errors = 0, checks = 0;

    initial begin
        for (int i = 0; i < 2; i++) begin
            tap_m[i] = 0; load_cnt[i] = 0; clr_cnt[i] = 0; move_cnt[i] = 0;
            pmap[i] = '0; oor_at[i] = 32;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            logic p;
            p        = pmap[i][tap_m[i] % 32];
            oor[i]   = (tap_m[i] >= oor_at[i]);
            early[i] = !p && (tap_m[i] < 16);
            late[i]  = !p && (tap_m[i] >= 16);
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        move_prev <= move;
        for (int i = 0; i < 2; i++) begin
            if (load[i]) tap_m[i] <= 0;
            else if (move[i]) tap_m[i] <= tap_m[i] + (dir[i] ? 1 : -1);
            if (load[i]) load_cnt[i] <= load_cnt[i] + 1;
            if (clr[i]) clr_cnt[i] <= clr_cnt[i] + 1;
            if (move[i]) move_cnt[i] <= move_cnt[i] + 1;
            if (move[i] && !dir[i]) dir_err <= dir_err + 1;
            if (move[i] && move_prev[i]) adj_err <= adj_err + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            b_load[i] = load_cnt[i]; b_clr[i] = clr_cnt[i]; b_move[i] = move_cnt[i];
        end
    endtask

    // START at edge N: BUSY and lane-0 LOAD visible in cycle N+1, old results cleared
    task automatic do_start(input string tag);
        snap();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1;
        check({tag, "_busy_n1"}, busy, 1);
        check({tag, "_load_n1"}, load, 2'b01);
        check({tag, "_clear_res"}, {done, fail, tap_out}, 0);
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({tag, "_done"}, {done, busy}, 2'b10);
    endtask

    initial begin
        int c0;
        // Reset state
        #2 rst_n = 1'b0;
        #3 check("reset_outputs", {busy, done, load, move, dir, clr, fail, tap_out}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // A: lane0 10..19, lane1 3..6 and 20..28
        pmap[0] = rng(10, 19); pmap[1] = rng(3, 6) | rng(20, 28);
        do_start("A");
        c0 = 0;
        for (int k = 0; k < 20; k++) begin
            if (clr[0]) break;
            @(negedge clk);
        end
        c0 = cyc;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            if (clr[0]) break;
            @(negedge clk);
        end
        check("A_clear_spacing", cyc - c0, 5);
        // START while busy must be ignored
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("A_busy_start", {busy, done, fail, tap_out}, {1'b1, 13'd0});
        wait_done("A");
        check("A_tap_out", tap_out, {5'd24, 5'd15});
        check("A_fail", fail, 0);
        check("A_iod_taps", {tap_m[1][7:0], tap_m[0][7:0]}, {8'd24, 8'd15});
        check("A_clears", {clr_cnt[1] - b_clr[1], clr_cnt[0] - b_clr[0]}, {32'd32, 32'd32});
        check("A_loads", {load_cnt[1] - b_load[1], load_cnt[0] - b_load[0]}, {32'd2, 32'd2});
        check("A_moves", {move_cnt[1] - b_move[1], move_cnt[0] - b_move[0]}, {32'd55, 32'd46});
        repeat (3) @(negedge clk);
        check("A_done_hold", {done, busy}, 2'b10);

        // B: lane1 window too narrow
        pmap[1] = rng(5, 6);
        do_start("B");
        wait_done("B");
        check("B_fail", fail, 2'b10);
        check("B_tap_out", tap_out, {5'd0, 5'd15});
        check("B_lane1_tap", tap_m[1], 0);
`ifdef PF_DDR4_DQS_TRAIN_RETRY_EN
        check("B_lane1_samples", clr_cnt[1] - b_clr[1], 64);
        check("B_lane1_moves", move_cnt[1] - b_move[1], 62);
        check("B_lane1_loads", load_cnt[1] - b_load[1], 3);
`else
        check("B_lane1_samples", clr_cnt[1] - b_clr[1], 32);
        check("B_lane1_moves", move_cnt[1] - b_move[1], 31);
        check("B_lane1_loads", load_cnt[1] - b_load[1], 2);
`endif

        // C: out-of-range truncates lane0; lane1 window reaches the last tap
        pmap[0] = rng(8, 20); oor_at[0] = 12; pmap[1] = rng(27, 31);
        do_start("C");
        wait_done("C");
        check("C_tap_out", tap_out, {5'd29, 5'd10});
        check("C_fail", fail, 0);
        check("C_lane0_samples", clr_cnt[0] - b_clr[0], 13);
        check("C_lane0_moves", move_cnt[0] - b_move[0], 22);
        check("C_lane1_moves", move_cnt[1] - b_move[1], 60);

        // D: equal windows resolve to earliest; full-range window of 32 taps
        pmap[0] = rng(2, 6) | rng(20, 24); oor_at[0] = 32; pmap[1] = rng(0, 31);
        do_start("D");
        wait_done("D");
        check("D_tap_out", tap_out, {5'd16, 5'd4});
        check("D_fail", fail, 0);
        check("D_iod_taps", {tap_m[1][7:0], tap_m[0][7:0]}, {8'd16, 8'd4});

        // E: reset during lane1 sweep, then retrain
        pmap[0] = rng(10, 19); pmap[1] = rng(3, 6) | rng(20, 28);
        do_start("E");
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (clr_cnt[1] - b_clr[1] >= 3) break;
        end
        check("E_reached_lane1", (clr_cnt[1] - b_clr[1]) >= 3, 1);
        @(posedge clk) #2 rst_n = 1'b0;
        #1 check("E_reset_outputs", {busy, done, load, move, dir, clr, fail, tap_out}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        do_start("E2");
        wait_done("E2");
        check("E2_tap_out", tap_out, {5'd24, 5'd15});
        check("E2_fail", fail, 0);

        check("move_direction", dir_err, 0);
        check("move_spacing", adj_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
